vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA 640x480@60 sync generator.
- Samples incoming hsync/vsync on the pixel tick, recovers pixel coordinates and video_on, and measures line and frame periods.
- Declares lock after consecutive well-formed frames; flags timing errors and loss of sync.
- Sits on the capture path: scaler/overlay logic or a loopback checker on the generator output.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, pixel ticks per line
HS_START, 656, x position of hsync leading edge (H_ACTIVE + right border)
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame
VS_START, 490, y position of vsync leading edge
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_en  in  1  pixel tick; all sampling and counting are qualified by it
hsync_in  in  1  horizontal sync, active-high pulse
vsync_in  in  1  vertical sync, active-high pulse
pixel_x  out  10  recovered column
pixel_y  out  10  recovered row
video_on  out  1  locked && pixel_x<H_ACTIVE && pixel_y<V_ACTIVE (combinational from registers)
locked  out  1  timing lock
frame_start  out  1  one-clk pulse on the cycle after a vsync leading edge is sampled
err  out  1  one-clk pulse: bad line or frame length while in TRAIN or LOCKED
sync_lost  out  1  one-clk pulse on timeout
h_meas  out  11  last measured line length in ticks
v_meas  out  10  last measured frame length in lines

Behaviour:
- Reset (async): all counters 0, hs_d/vs_d 0, state SEARCH. Outputs pixel_x=0, pixel_y=0, locked=0, h_meas=0, v_meas=0; all pulse outputs 0.
- Edge detect: hs_d/vs_d update only on pix_en. hrise = pix_en & hsync_in & ~hs_d. vrise likewise. Nothing changes when pix_en=0.
- x counter, priority order:
  - hrise: x <= HS_START.
  - Else if x==H_TOTAL-1: x <= 0 and y advances (wraps V_TOTAL-1 -> 0).
  - Else x+1.
- y counter: vrise forces y <= VS_START and overrides a same-cycle y advance.
- All outputs are registered. Latency from sampled edge to loaded coordinate is 1 clk.
- Line measure: hcnt counts pix_en ticks. On hrise: h_meas <= hcnt, hcnt <= 1. Otherwise hcnt+1, saturating at 2047. A line is good iff the value captured equals H_TOTAL. The first hrise after SEARCH entry is never judged.
- Frame measure: vcnt counts hrise events, saturating at 1023. On vrise: v_meas <= vcnt, vcnt <= 0. A frame is good iff vcnt==V_TOTAL and no bad line occurred since the previous vrise. A same-sample hrise counts toward the new frame.
- FSM:
  - SEARCH: on first vrise -> TRAIN; clear line_bad flag and good_frames.
  - TRAIN: each vrise:
    - Good frame: good_frames+1. Reaching LOCK_FRAMES -> LOCKED.
    - Bad frame: good_frames <= 0, err pulse, stay in TRAIN.
  - LOCKED: locked=1. A bad line (judged at hrise) or bad frame -> err pulse, TRAIN, good_frames 0; locked falls on the same edge.
  - Any state: hcnt reaching 2*H_TOTAL with no hrise -> SEARCH, sync_lost pulse (only if not already in SEARCH), locked 0.
- Coordinates keep free-running in every state. video_on is gated by locked.
- Reset mid-frame: immediate return to reset values; the next lock requires the full SEARCH -> TRAIN sequence.

Optional Feature:
VGA_MON_ERRCNT_EN
- Defined: adds output err_count (8 bits), incremented on each err or sync_lost pulse, saturating at 255, cleared only by rst. If err and sync_lost coincide, the count increments by 1.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
1. Ideal 800x525 stream (hsync high at x 656..751, vsync high at lines 490..491, pix_en every 2nd clk), default parameters -> locked rises at the 3rd vrise (SEARCH + 2 good frames); h_meas=800, v_meas=525; pixel_x==656 one clk after each hrise; frame_start once per frame.
2. Locked, then one line shortened to 799 ticks -> err pulse at that hrise, locked=0 the same edge, h_meas=799; relock 2 frames later.
3. Locked, then a frame of 524 lines -> err at vrise, v_meas=524, locked=0.
4. Hold hsync_in low for 1700 ticks while locked -> sync_lost pulse when hcnt hits 1600, state SEARCH, video_on=0.
5. Assert rst mid-line with pixel_x=300 -> all outputs 0 asynchronously; after release, no lock before vrise #3.
6. pix_en held low for 100 clks with toggling sync inputs -> no counter, output, or state change.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// VGA receive-side sync monitor: recovers pixel coordinates, measures line/frame periods, tracks lock.
// Optional build macro VGA_MON_ERRCNT_EN adds a saturating err_count output.
module vga_sync_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int HS_START    = 656,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int VS_START    = 490,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic        sync_lost,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas
`ifdef VGA_MON_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t      state;
  logic        hs_d, vs_d;
  logic        judge_ok, line_bad;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [3:0]  good_frames;

  logic hrise, vrise, bad_line, timeout, frame_good;

  assign hrise      = pix_en & hsync_in & ~hs_d;
  assign vrise      = pix_en & vsync_in & ~vs_d;
  // A line is only judged once a full line has been seen since entering SEARCH.
  assign bad_line   = hrise & judge_ok & (hcnt != 11'(H_TOTAL));
  assign timeout    = pix_en & ~hrise & (hcnt == 11'(2*H_TOTAL-1));
  assign frame_good = (vcnt == 10'(V_TOTAL)) & ~line_bad;
  assign video_on   = locked & (pixel_x < 10'(H_ACTIVE)) & (pixel_y < 10'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pix_en) begin
      if (hrise)
        pixel_x <= 10'(HS_START);
      else if (pixel_x == 10'(H_TOTAL-1)) begin
        pixel_x <= '0;
        pixel_y <= (pixel_y == 10'(V_TOTAL-1)) ? '0 : pixel_y + 10'd1;
      end else
        pixel_x <= pixel_x + 10'd1;
      // vsync realignment wins over the line-wrap advance
      if (vrise) pixel_y <= 10'(VS_START);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
      h_meas   <= '0;
      v_meas   <= '0;
      judge_ok <= 1'b0;
      line_bad <= 1'b0;
    end else if (pix_en) begin
      hs_d <= hsync_in;
      vs_d <= vsync_in;
      if (hrise) begin
        h_meas <= hcnt;
        hcnt   <= 11'd1;
      end else if (hcnt != 11'h7FF)
        hcnt <= hcnt + 11'd1;
      // an hsync sampled together with vsync belongs to the new frame
      if (vrise) begin
        v_meas <= vcnt;
        vcnt   <= {9'd0, hrise};
      end else if (hrise && vcnt != 10'h3FF)
        vcnt <= vcnt + 10'd1;
      if (timeout)    judge_ok <= 1'b0;
      else if (hrise) judge_ok <= 1'b1;
      if (vrise)
        line_bad <= bad_line & (state != SEARCH);
      else if (bad_line && state != SEARCH)
        line_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_frames <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      sync_lost   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      err         <= 1'b0;
      sync_lost   <= 1'b0;
      frame_start <= vrise;
      if (timeout) begin
        sync_lost <= (state != SEARCH);
        state     <= SEARCH;
        locked    <= 1'b0;
      end else begin
        case (state)
          SEARCH: if (vrise) begin
            state       <= TRAIN;
            good_frames <= '0;
          end
          TRAIN: if (vrise) begin
            if (frame_good) begin
              good_frames <= good_frames + 4'd1;
              if (good_frames + 4'd1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_frames <= '0;
              err         <= 1'b1;
            end
          end
          LOCKED: if (bad_line || (vrise && !frame_good)) begin
            err         <= 1'b1;
            state       <= TRAIN;
            locked      <= 1'b0;
            good_frames <= '0;
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_MON_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if ((err || sync_lost) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor: synthetic VGA source, event-level reference model, per-cycle compare.
module tb_vga_sync_monitor;
  localparam int HA = 16, HT = 24, HS = 18, HW = 4;
  localparam int VA = 8, VT = 12, VSS = 9, VW = 2, LF = 2;

  logic clk = 0, rst = 1, pix_en = 0, hsync_in = 0, vsync_in = 0;
  logic [9:0] pixel_x, pixel_y, v_meas;
  logic [10:0] h_meas;
  logic video_on, locked, frame_start, err, sync_lost;

  vga_sync_monitor #(.H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HS), .V_ACTIVE(VA),
                     .V_TOTAL(VT), .VS_START(VSS), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .locked(locked),
    .frame_start(frame_start), .err(err), .sync_lost(sync_lost), .h_meas(h_meas), .v_meas(v_meas));

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int x, y, vo, lk, fs, er, sl, hm, vm;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0, cyc_no = 0;
  int n_fs = 0, n_err = 0, n_lost = 0;
  int gap_max = 1;
  bit rnd_mode = 0;

  // reference model: mode 0=search 1=train 2=locked; line/frame lengths kept unbounded
  int mx, my, m_line, m_lines, m_hm, m_vm, m_mode, m_good;
  bit m_hs, m_vs, m_judge, m_bad, e_fs, e_err, e_lost;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc_no, act, exp);
    end
  endtask

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; m_line = 0; m_lines = 0; m_hm = 0; m_vm = 0; m_mode = 0; m_good = 0;
    m_hs = 0; m_vs = 0; m_judge = 0; m_bad = 0; e_fs = 0; e_err = 0; e_lost = 0;
  endtask

  task automatic model_tick(bit hs, bit vs);
    bit hr, vr, bad, tmo, fok;
    int pm;
    hr = hs && !m_hs;
    vr = vs && !m_vs;
    m_hs = hs; m_vs = vs;
    pm = m_mode;
    bad = hr && m_judge && (m_line != HT);
    tmo = !hr && (m_line + 1 == 2*HT);
    fok = (m_lines == VT) && !m_bad;
    e_fs = vr;
    if (hr) mx = HS;
    else if (mx == HT-1) begin mx = 0; my = (my + 1) % VT; end
    else mx++;
    if (vr) my = VSS;
    if (hr) begin m_hm = mn(m_line, 2047); m_line = 1; end
    else m_line++;
    if (vr) begin m_vm = mn(m_lines, 1023); m_lines = hr ? 1 : 0; end
    else if (hr) m_lines++;
    if (vr) m_bad = bad && pm != 0;
    else if (bad && pm != 0) m_bad = 1;
    if (tmo) begin
      e_lost = (m_mode != 0); m_mode = 0; m_judge = 0;
    end else begin
      if (hr) m_judge = 1;
      case (m_mode)
        0: if (vr) begin m_mode = 1; m_good = 0; end
        1: if (vr) begin
             if (fok) begin m_good++; if (m_good == LF) m_mode = 2; end
             else begin m_good = 0; e_err = 1; end
           end
        default: if (bad || (vr && !fok)) begin e_err = 1; m_mode = 1; m_good = 0; end
      endcase
    end
  endtask

  task automatic push();
    exp_t e;
    e.tag = cyc_no + 1;
    e.x = mx; e.y = my; e.lk = (m_mode == 2);
    e.vo = (m_mode == 2 && mx < HA && my < VA);
    e.fs = e_fs; e.er = e_err; e.sl = e_lost;
    e.hm = mn(m_hm, 2047); e.vm = mn(m_vm, 1023);
    q.push_back(e);
  endtask

  task automatic cyc(bit pe, bit hs, bit vs);
    pix_en = pe; hsync_in = hs; vsync_in = vs;
    e_fs = 0; e_err = 0; e_lost = 0;
    if (pe) model_tick(hs, vs);
    push();
    @(posedge clk); #2;
  endtask

  task automatic pix(bit hs, bit vs);
    int g;
    cyc(1'b1, hs, vs);
    g = (gap_max == 0) ? 0 : $urandom_range(1, gap_max);
    for (int i = 0; i < g; i++) cyc(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(int nl, int bad_idx, int bad_len, bit no_vs);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == bad_idx) ? bad_len : HT;
      if (rnd_mode && $urandom_range(0, 19) == 0) len = HT + ($urandom_range(0, 1) ? 1 : -1);
      for (int p = 0; p < len; p++)
        pix(p >= HS && p < HS + HW, !no_vs && l >= VSS && l < VSS + VW);
    end
  endtask

  task automatic ideal(int n);
    for (int i = 0; i < n; i++) send_frame(VT, -1, HT, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc_no++;
    #1;
    if (frame_start) n_fs++;
    if (err) n_err++;
    if (sync_lost) n_lost++;
    if (q.size() > 0 && q[0].tag == cyc_no) begin
      e = q.pop_front();
      chk("pixel_x", int'(pixel_x), e.x);
      chk("pixel_y", int'(pixel_y), e.y);
      chk("video_on", int'(video_on), e.vo);
      chk("locked", int'(locked), e.lk);
      chk("frame_start", int'(frame_start), e.fs);
      chk("err", int'(err), e.er);
      chk("sync_lost", int'(sync_lost), e.sl);
      chk("h_meas", int'(h_meas), e.hm);
      chk("v_meas", int'(v_meas), e.vm);
    end
  end

  initial begin
    int base;
    model_reset();
    repeat (3) begin push(); @(posedge clk); #2; end
    rst = 0;

    // A: ideal stream, lock on 3rd vsync
    base = n_fs;
    ideal(2);
    chk("A_no_lock_after_2", int'(locked), 0);
    ideal(2);
    chk("A_locked", int'(locked), 1);
    chk("A_h_meas", int'(h_meas), HT);
    chk("A_v_meas", int'(v_meas), VT);
    chk("A_frame_starts", n_fs - base, 4);

    // B: one short line while locked
    base = n_err;
    send_frame(VT, 3, HT - 1, 1'b0);
    chk("B_unlocked", int'(locked), 0);
    chk("B_err_pulses", n_err - base, 2);
    ideal(2);
    chk("B_relocked", int'(locked), 1);

    // C: one short frame
    send_frame(VT - 1, -1, HT, 1'b0);
    base = n_err;
    ideal(1);
    chk("C_v_meas", int'(v_meas), VT - 1);
    chk("C_unlocked", int'(locked), 0);
    chk("C_err_pulses", n_err - base, 1);
    ideal(2);
    chk("C_relocked", int'(locked), 1);

    // D: hsync disappears
    base = n_lost;
    for (int i = 0; i < 2100; i++) pix(1'b0, 1'b0);
    chk("D_sync_lost", n_lost - base, 1);
    chk("D_unlocked", int'(locked), 0);
    chk("D_video_off", int'(video_on), 0);
    ideal(3);
    chk("D_relocked", int'(locked), 1);

    // E: async reset mid-line
    for (int p = 0; p < 10; p++) pix(1'b0, 1'b0);
    rst = 1; #1;
    chk("E_rst_x", int'(pixel_x), 0);
    chk("E_rst_y", int'(pixel_y), 0);
    chk("E_rst_locked", int'(locked), 0);
    chk("E_rst_video", int'(video_on), 0);
    chk("E_rst_hmeas", int'(h_meas), 0);
    chk("E_rst_vmeas", int'(v_meas), 0);
    model_reset();
    pix_en = 0;
    repeat (2) begin push(); @(posedge clk); #2; end
    rst = 0;
    ideal(2);
    chk("E_no_lock_after_2", int'(locked), 0);
    ideal(1);
    chk("E_relocked", int'(locked), 1);

    // F: randomized line and frame lengths, irregular pixel ticks
    gap_max = 2; rnd_mode = 1;
    for (int f = 0; f < 6; f++) send_frame(VT - 1 + $urandom_range(0, 2), -1, HT, 1'b0);
    rnd_mode = 0; gap_max = 0;

    // G: long vsync-free stretch saturates the frame counter
    send_frame(1030, -1, HT, 1'b1);
    ideal(1);
    chk("G_v_meas_sat", int'(v_meas), 1023);
    gap_max = 1;
    ideal(3);

    @(posedge clk); #3;
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
